rns_forward_converter: RTL and testbench

- Sequential binary-to-RNS forward converter for the 3-bit residue datapath.
- Accepts one unsigned binary operand per transaction and produces its residues modulo three fixed moduli.
- Computes the residues bit-serially, MSB first.
- Sits directly upstream of the per-channel 3-bit modular adders; each res_* output feeds one adder channel's residue input, and the matching MOD_* value drives that adder's moduli input.

---
 rtl/rns_forward_converter.sv | 98 +++++++++
 tb/tb_rns_forward_converter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rns_forward_converter.sv
// Bit-serial binary-to-RNS forward converter: MSB-first residue accumulation
// for three fixed 3-bit moduli with a valid/ready handshake on each side.
module rns_forward_converter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MOD_A      = 7,
    parameter int unsigned MOD_B      = 5,
    parameter int unsigned MOD_C      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            res_a,
    output logic [2:0]            res_b,
    output logic [2:0]            res_c,
    output logic                  busy
);

    if (DATA_WIDTH < 2 || DATA_WIDTH > 32 ||
        MOD_A < 2 || MOD_A > 7 || MOD_B < 2 || MOD_B > 7 ||
        MOD_C < 2 || MOD_C > 7) begin : g_param_check
        $error("rns_forward_converter: parameter out of legal range");
    end

    localparam int unsigned CntWidth = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [3:0]  ModA     = 4'(MOD_A);
    localparam logic [3:0]  ModB     = 4'(MOD_B);
    localparam logic [3:0]  ModC     = 4'(MOD_C);

    typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [CntWidth-1:0]     cnt_q;
    logic [2:0]              res_a_q, res_b_q, res_c_q;
    logic                    msb;

    // r < m guarantees 2r+b <= 2m-1, so a single conditional subtract suffices.
    function automatic logic [2:0] fold(input logic [2:0] r, input logic b,
                                        input logic [3:0] m);
        logic [3:0] t;
        t = {r, b};
        return (t >= m) ? 3'(t - m) : t[2:0];
    endfunction

    assign msb = shift_q[DATA_WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            res_a_q <= '0;
            res_b_q <= '0;
            res_c_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        shift_q <= in_data;
                        cnt_q   <= CntWidth'(DATA_WIDTH - 1);
                        res_a_q <= '0;
                        res_b_q <= '0;
                        res_c_q <= '0;
                        state_q <= StConvert;
                    end
                end
                StConvert: begin
                    res_a_q <= fold(res_a_q, msb, ModA);
                    res_b_q <= fold(res_b_q, msb, ModB);
                    res_c_q <= fold(res_c_q, msb, ModC);
                    shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StConvert);
    assign out_valid = (state_q == StDone);
    assign res_a     = res_a_q;
    assign res_b     = res_b_q;
    assign res_c     = res_c_q;

endmodule

// File: tb/tb_rns_forward_converter.sv
// Directed bench for rns_forward_converter: default 8-bit 7/5/3 instance plus a
// 12-bit 7/6/5 instance, with hand-computed residues and a modulo sweep.
module tb_rns_forward_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  in_data;
    logic [2:0]  res_a, res_b, res_c;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [11:0] in_data2;
    logic [2:0]  res_a2, res_b2, res_c2;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;
    int n, t0, t1;

    rns_forward_converter #(
        .DATA_WIDTH(8), .MOD_A(7), .MOD_B(5), .MOD_C(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .res_a(res_a), .res_b(res_b), .res_c(res_c), .busy(busy)
    );

    rns_forward_converter #(
        .DATA_WIDTH(12), .MOD_A(7), .MOD_B(6), .MOD_C(5)
    ) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .res_a(res_a2), .res_b(res_b2), .res_c(res_c2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, check the residue bound.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("inv_a", 32'(res_a < 3'd7), 1);
        chk("inv_b", 32'(res_b < 3'd5), 1);
        chk("inv_c", 32'(res_c < 3'd3), 1);
    endtask

    task automatic wait_out(input string tag, output int cnt);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk({tag, "_timeout"}, 32'(out_valid), 1);
    endtask

    task automatic chk_res(input string tag, input int ea, input int eb, input int ec);
        chk({tag, "_a"}, 32'(res_a), ea);
        chk({tag, "_b"}, 32'(res_b), eb);
        chk({tag, "_c"}, 32'(res_c), ec);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk_res("rst_res", 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single conversion of 200, counting busy cycles.
        in_valid = 1'b1; in_data = 8'd200; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("busy_cycles", n, 8);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk_res("t1_200", 4, 0, 2);
        tick();
        chk("t1_valid_fall", 32'(out_valid), 0);
        chk("t1_ready_rise", 32'(in_ready), 1);
        chk_res("t1_hold", 4, 0, 2);

        // Back-to-back 0, 255, 127 with 10-cycle period.
        in_valid = 1'b1; in_data = 8'd0;
        tick();
        wait_out("b2b0", n);
        chk("b2b0_lat", n, 8);
        chk_res("b2b_0", 0, 0, 0);
        t0 = cyc;
        in_data = 8'd255;
        wait_out("b2b1", n);
        tick();
        wait_out("b2b1", n);
        t1 = cyc;
        chk("b2b_period1", t1 - t0, 10);
        chk_res("b2b_255", 3, 0, 0);
        in_data = 8'd127;
        tick();
        wait_out("b2b2", n);
        chk("b2b_period2", cyc - t1, 10);
        chk_res("b2b_127", 1, 2, 1);
        in_valid = 1'b0;
        tick();

        // Backpressure with a pending second operand.
        in_valid = 1'b1; in_data = 8'd200; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_out("bp", n);
        in_valid = 1'b1; in_data = 8'd13;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk_res("bp_hold", 4, 0, 2);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_ready_back", 32'(in_ready), 1);
        chk_res("bp_idle_hold", 4, 0, 2);
        tick();
        in_valid = 1'b0;
        chk("bp_accept13", 32'(busy), 1);
        wait_out("bp13", n);
        chk_res("bp_13", 6, 3, 1);
        tick();

        // Asynchronous reset on the 4th CONVERT cycle.
        in_valid = 1'b1; in_data = 8'd200;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_in_ready", 32'(in_ready), 1);
        chk("mid_busy_clr", 32'(busy), 0);
        chk("mid_out_valid", 32'(out_valid), 0);
        chk_res("mid_res", 0, 0, 0);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) n++;
        end
        chk("mid_no_pulse", n, 0);
        in_valid = 1'b1; in_data = 8'd99;
        tick();
        in_valid = 1'b0;
        wait_out("mid99", n);
        chk_res("mid_99", 1, 4, 0);
        tick();

        // Sweep every operand with random output stalls.
        for (int v = 0; v < 256; v++) begin
            in_valid = 1'b1; in_data = 8'(v);
            tick();
            in_valid = 1'b0;
            wait_out("sweep", n);
            chk_res($sformatf("sweep_%0d", v), v % 7, v % 5, v % 3);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            chk_res($sformatf("sweep_stall_%0d", v), v % 7, v % 5, v % 3);
            out_ready = 1'b1;
            tick();
        end

        // 12-bit instance with moduli 7/6/5.
        in_valid2 = 1'b1; in_data2 = 12'd4095;
        tick();
        in_valid2 = 1'b0;
        n = 0;
        while (busy2 === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("w12_busy_cycles", n, 12);
        chk("w12_out_valid", 32'(out_valid2), 1);
        chk("w12_a", 32'(res_a2), 0);
        chk("w12_b", 32'(res_b2), 3);
        chk("w12_c", 32'(res_c2), 0);
        tick();
        chk("w12_in_ready", 32'(in_ready2), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
